// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit multi-mode shift register with LSB-first serialiser FSM; optional USR_PARITY_EN adds a parity output
module universal_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic sout_q, sout_d, done_q, done_d;
  // state and datapath registers, synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      q_q <= '0;
      sout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      sout_q <= sout_d;
      done_q <= done_d;
    end
  end
  // next state: start launches a burst, the WIDTH-th shift ends it
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start) state_d = SHIFT;
    else if (state_q == SHIFT && cnt_q == LAST) state_d = IDLE;
  end
  // datapath: burst shifting, start capture, or the manual mode operation
  always_comb begin
    q_d = q_q;
    sout_d = sout_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    if (state_q == SHIFT) begin
      q_d = {sin, q_q[WIDTH-1:1]};
      sout_d = q_q[0];
      cnt_d = cnt_q + CW'(1);
      done_d = cnt_q == LAST;
    end else if (start) begin
      q_d = d;
      cnt_d = '0;
    end else if (en) begin
      case (mode)
        3'b000: q_d = q_q;
        3'b001: q_d = d;
        3'b010: begin q_d = {q_q[WIDTH-2:0], sin}; sout_d = q_q[WIDTH-1]; end
        3'b011: begin q_d = {sin, q_q[WIDTH-1:1]}; sout_d = q_q[0]; end
        3'b100: begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; sout_d = q_q[WIDTH-1]; end
        3'b101: begin q_d = {q_q[0], q_q[WIDTH-1:1]}; sout_d = q_q[0]; end
        3'b110: begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; sout_d = q_q[0]; end
        default: begin q_d = '0; sout_d = 1'b0; end
      endcase
    end
  end
  assign q = q_q;
  assign q_n = ~q_q;
  assign sout = sout_q;
  assign busy = state_q == SHIFT;
  assign done = done_q;
`ifdef USR_PARITY_EN
  assign parity = ^q_q;
`endif
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb_universal_shift_reg: randomized self-checking bench against a behavioural model of universal_shift_reg
module tb_universal_shift_reg;
  logic clk = 1'b0;
  logic reset = 1'b0, en = 1'b0, sin = 1'b0, start = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] d = 8'd0;
  logic [7:0] q, q_n;
  logic sout, busy, done;
`ifdef USR_PARITY_EN
  logic parity;
`endif
  int n_pass = 0, n_total = 0;
  logic [7:0] m_q;
  logic m_sout, m_busy, m_done;
  int m_rem;

  universal_shift_reg #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .sin(sin), .start(start),
    .q(q), .q_n(q_n), .sout(sout), .busy(busy), .done(done)
`ifdef USR_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic [7:0] old;
    @(posedge clk);
    old = m_q;
    if (reset) begin
      m_q = 8'h00; m_sout = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_sout = old[0];
      m_q = (old >> 1) | (sin ? 8'h80 : 8'h00);
      m_rem = m_rem - 1;
      m_done = (m_rem == 0);
      m_busy = (m_rem > 0);
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_q = d; m_rem = 8; m_busy = 1'b1;
      end else if (en) begin
        case (mode)
          3'd1: m_q = d;
          3'd2: begin m_q = (old << 1) | {7'd0, sin}; m_sout = old[7]; end
          3'd3: begin m_q = (old >> 1) | (sin ? 8'h80 : 8'h00); m_sout = old[0]; end
          3'd4: begin m_q = (old << 1) | (old >> 7); m_sout = old[7]; end
          3'd5: begin m_q = (old >> 1) | (old << 7); m_sout = old[0]; end
          3'd6: begin m_q = 8'($signed(old) >>> 1); m_sout = old[0]; end
          3'd7: begin m_q = 8'h00; m_sout = 1'b0; end
          default: ;
        endcase
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      reset = 1'b1; en = 1'($urandom); start = 1'($urandom); sin = 1'($urandom);
      mode = 3'($urandom); d = 8'($urandom);
      tick();
    end
    n_total++;
    if ({q, q_n, sout, busy, done} !== {8'h00, 8'hFF, 3'b000})
      $display("FAIL reset: q=%h q_n=%h sout=%b busy=%b done=%b, want 00 FF 0 0 0", q, q_n, sout, busy, done);
    else n_pass++;
    reset = 1'b0; start = 1'b0; en = 1'b0;
    tick();
    n_total++;
    if ({q, busy, done} !== {8'h00, 2'b00})
      $display("FAIL reset_hold: q=%h busy=%b done=%b, want 00 0 0", q, busy, done);
    else n_pass++;
  endtask

  task automatic test_modes();
    logic [2:0] modes [5] = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd7};
    logic [7:0] exp_q [5] = '{8'hA5, 8'h4B, 8'hA5, 8'hD2, 8'h00};
    logic exp_s [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    en = 1'b1; d = 8'hA5; sin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mode = modes[i];
      tick();
      n_total++;
      if (q !== exp_q[i] || q_n !== ~exp_q[i] || sout !== exp_s[i])
        $display("FAIL mode%0d: q=%h q_n=%h sout=%b, want %h %h %b", modes[i], q, q_n, sout, exp_q[i], ~exp_q[i], exp_s[i]);
      else n_pass++;
    end
    for (int i = 0; i < 60; i++) begin
      en = 1'($urandom); mode = 3'($urandom); d = 8'($urandom); sin = 1'($urandom);
      tick();
      n_total++;
      if ({q, q_n, sout, busy, done} !== {m_q, ~m_q, m_sout, m_busy, m_done})
        $display("FAIL rand_mode: q=%h q_n=%h sout=%b busy=%b done=%b, want %h %h %b %b %b", q, q_n, sout, busy, done, m_q, ~m_q, m_sout, m_busy, m_done);
      else n_pass++;
    end
    en = 1'b0;
  endtask

  task automatic test_burst();
    logic seq [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    d = 8'hB4; sin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1 || q !== 8'hB4 || done !== 1'b0)
      $display("FAIL burst_accept: busy=%b q=%h done=%b, want 1 b4 0", busy, q, done);
    else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      en = 1'($urandom); mode = 3'($urandom);
      tick();
      n_total++;
      if (sout !== seq[k-1] || busy !== (k < 8) || done !== (k == 8))
        $display("FAIL burst_shift%0d: sout=%b busy=%b done=%b, want %b %b %b", k, sout, busy, done, seq[k-1], k < 8, k == 8);
      else n_pass++;
    end
    n_total++;
    if (q !== 8'h00) $display("FAIL burst_final_q: q=%h, want 00", q);
    else n_pass++;
    en = 1'b0;
    tick();
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL burst_done_width: done=%b busy=%b, want 0 0", done, busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    d = 8'h0F; start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      sin = 1'($urandom);
      tick();
      dones += int'(done);
      n_total++;
      if ({q, q_n, sout, busy, done} !== {m_q, ~m_q, m_sout, m_busy, m_done})
        $display("FAIL b2b: q=%h sout=%b busy=%b done=%b, want %h %b %b %b", q, sout, busy, done, m_q, m_sout, m_busy, m_done);
      else n_pass++;
    end
    start = 1'b0;
    n_total++;
    if (dones !== 2) $display("FAIL b2b_done_count: got %0d, want 2", dones);
    else n_pass++;
    tick();
  endtask

  task automatic test_abort();
    d = 8'($urandom); start = 1'b1;
    tick();
    start = 1'b0; en = 1'b1; mode = 3'd1;
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom); sin = 1'($urandom);
      tick();
      n_total++;
      if (q !== m_q || busy !== 1'b1)
        $display("FAIL busy_ignore_load: q=%h busy=%b, want %h 1", q, busy, m_q);
      else n_pass++;
    end
    en = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if ({q, q_n, sout, busy, done} !== {8'h00, 8'hFF, 3'b000})
      $display("FAIL abort: q=%h q_n=%h sout=%b busy=%b done=%b, want 00 FF 0 0 0", q, q_n, sout, busy, done);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL abort_no_done: done=%b busy=%b, want 0 0", done, busy);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 29) == 0);
      start = ($urandom_range(0, 9) == 0);
      en = 1'($urandom); mode = 3'($urandom); d = 8'($urandom); sin = 1'($urandom);
      tick();
      n_total++;
      if ({q, q_n, sout, busy, done} !== {m_q, ~m_q, m_sout, m_busy, m_done})
        $display("FAIL random: q=%h q_n=%h sout=%b busy=%b done=%b, want %h %h %b %b %b", q, q_n, sout, busy, done, m_q, ~m_q, m_sout, m_busy, m_done);
      else n_pass++;
    end
    reset = 1'b0; start = 1'b0; en = 1'b0;
  endtask

`ifdef USR_PARITY_EN
  task automatic test_parity();
    logic [7:0] vals [2] = '{8'h07, 8'h03};
    logic exp_p [2] = '{1'b1, 1'b0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if (parity !== 1'b0) $display("FAIL parity_reset: got %b, want 0", parity);
    else n_pass++;
    en = 1'b1; mode = 3'd1;
    for (int i = 0; i < 2; i++) begin
      d = vals[i];
      tick();
      n_total++;
      if (parity !== exp_p[i]) $display("FAIL parity_%h: got %b, want %b", vals[i], parity, exp_p[i]);
      else n_pass++;
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_modes();
    test_burst();
    test_back_to_back();
    test_abort();
    test_random();
`ifdef USR_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
